// File: rtl/fp_sqrt_if.sv
// Operand and result bundle of the single-precision square-root core.
// The master drives the operand fields; the slave returns ready plus the result fields.
interface fp_sqrt_if;
   logic        i_sign;
   logic [7:0]  i_exp;
   logic [22:0] i_frac;
   logic        ready;
   logic        o_sign;
   logic [7:0]  o_exp;
   logic [22:0] o_frac;

   modport master (
      output i_sign, i_exp, i_frac,
      input  ready, o_sign, o_exp, o_frac
   );

   modport slave (
      input  i_sign, i_exp, i_frac,
      output ready, o_sign, o_exp, o_frac
   );
endinterface

// File: rtl/fp_sqrt.sv
// Multi-cycle IEEE-754 single-precision square root using a bit-serial restoring recurrence.
// Operands load while reset is high; the result appears 26 edges after release and holds until reset.
module fp_sqrt (
   input  logic     clk,
   input  logic     reset,
   fp_sqrt_if.slave io
);

   typedef enum logic [1:0] {S_LOAD, S_PREP, S_CALC, S_DONE} state_e;
   typedef enum logic [1:0] {K_NORMAL, K_ZERO, K_INF, K_NAN} kind_e;

   localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
   localparam logic [22:0] QNAN_FRAC    = 23'h400000;
   localparam logic [4:0]  LAST_ITER    = 5'd23;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        op_sign_q, op_sign_d;
   logic [7:0]  op_exp_q, op_exp_d;
   logic [22:0] op_frac_q, op_frac_d;
   kind_e       kind_q, kind_d;
   logic        res_sign_q, res_sign_d;
   logic [7:0]  res_exp_q, res_exp_d;
   logic [47:0] rad_q, rad_d;
   logic [25:0] rem_q, rem_d;
   logic [23:0] root_q, root_d;
   logic        ready_q, ready_d;
   logic        o_sign_q, o_sign_d;
   logic [7:0]  o_exp_q, o_exp_d;
   logic [22:0] o_frac_q, o_frac_d;

   logic        exp_odd;
   logic [25:0] rem_shift;
   logic [25:0] trial;
   logic        take;
   logic [25:0] rem_next;
   logic [23:0] root_next;

   always_comb begin
      // NOTE: every _d starts as its _q so no branch below can leave a value unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_sign_d  = op_sign_q;
      op_exp_d   = op_exp_q;
      op_frac_d  = op_frac_q;
      kind_d     = kind_q;
      res_sign_d = res_sign_q;
      res_exp_d  = res_exp_q;
      rad_d      = rad_q;
      rem_d      = rem_q;
      root_d     = root_q;
      ready_d    = ready_q;
      o_sign_d   = o_sign_q;
      o_exp_d    = o_exp_q;
      o_frac_d   = o_frac_q;

      if (reset) begin
         op_sign_d = io.i_sign;
         op_exp_d  = io.i_exp;
         op_frac_d = io.i_frac;
      end

      // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
      exp_odd   = op_exp_q[0];
      rem_shift = 26'({rem_q, rad_q[47:46]});
      trial     = {root_q, 2'b01};
      take      = (rem_shift >= trial);
      rem_next  = take ? (rem_shift - trial) : rem_shift;
      root_next = {root_q[22:0], take};

      case (state_q)
         S_LOAD: state_d = S_PREP;

         S_PREP: begin
            res_sign_d = 1'b0;
            if (op_exp_q == 8'd0) begin
               kind_d     = K_ZERO;
               res_sign_d = op_sign_q;
            end else if (op_exp_q == EXP_ALL_ONES && op_frac_q == 23'd0 && !op_sign_q) begin
               kind_d = K_INF;
            end else if (op_exp_q == EXP_ALL_ONES || op_sign_q) begin
               kind_d = K_NAN;
            end else begin
               kind_d = K_NORMAL;
            end
            // An odd biased exponent means an even unbiased one, so the significand is used as is.
            res_exp_d = 8'(({1'b0, op_exp_q} + (exp_odd ? 9'd127 : 9'd126)) >> 1);
            rad_d     = exp_odd ? {1'b0, 1'b1, op_frac_q, 23'd0} : {1'b1, op_frac_q, 24'd0};
            rem_d     = '0;
            root_d    = '0;
            cnt_d     = '0;
            state_d   = S_CALC;
         end

         S_CALC: begin
            rad_d  = {rad_q[45:0], 2'b00};
            rem_d  = rem_next;
            root_d = root_next;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) begin
               state_d = S_DONE;
               ready_d = 1'b1;
               case (kind_q)
                  K_NORMAL: begin
                     o_sign_d = 1'b0;
                     o_exp_d  = res_exp_q;
                     o_frac_d = root_next[22:0];
                  end
                  K_ZERO: begin
                     o_sign_d = res_sign_q;
                     o_exp_d  = 8'd0;
                     o_frac_d = 23'd0;
                  end
                  K_INF: begin
                     o_sign_d = 1'b0;
                     o_exp_d  = EXP_ALL_ONES;
                     o_frac_d = 23'd0;
                  end
                  default: begin
                     o_sign_d = 1'b0;
                     o_exp_d  = EXP_ALL_ONES;
                     o_frac_d = QNAN_FRAC;
                  end
               endcase
            end
         end

         default: ;
      endcase
   end

   // NOTE: flops use non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_LOAD;
         ready_q  <= 1'b0;
         o_sign_q <= 1'b0;
         o_exp_q  <= 8'd0;
         o_frac_q <= 23'd0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         o_sign_q <= o_sign_d;
         o_exp_q  <= o_exp_d;
         o_frac_q <= o_frac_d;
      end
   end

   // NOTE: datapath registers carry no reset; PREP initialises them before any use.
   always_ff @(posedge clk) begin
      op_sign_q  <= op_sign_d;
      op_exp_q   <= op_exp_d;
      op_frac_q  <= op_frac_d;
      cnt_q      <= cnt_d;
      kind_q     <= kind_d;
      res_sign_q <= res_sign_d;
      res_exp_q  <= res_exp_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
   end

   assign io.ready  = ready_q;
   assign io.o_sign = o_sign_q;
   assign io.o_exp  = o_exp_q;
   assign io.o_frac = o_frac_q;

endmodule

// File: tb/tb_fp_sqrt.sv
// Self-checking bench for fp_sqrt: directed vectors, reset/abort sequences and random
// operands compared against an integer-search square-root model.
module tb_fp_sqrt;

   logic clk = 1'b0;
   logic reset = 1'b1;

   fp_sqrt_if io ();

   fp_sqrt dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        s;
      logic [7:0]  e;
      logic [22:0] f;
      logic [31:0] res;
   } vec_t;

   localparam logic [31:0] QNAN = {1'b0, 8'hFF, 23'h400000};

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [32:0] dut_out();
      return {io.ready, io.o_sign, io.o_exp, io.o_frac};
   endfunction

   // Reference: sqrt(1.f * 2^ue) with ue made even, fraction found by integer binary search.
   function automatic logic [31:0] sqrt_model(input logic s, input logic [7:0] e, input logic [22:0] f);
      longint unsigned scaled, lo, hi, mid;
      int ue;
      if (e == 8'd0) return {s, 31'd0};
      if (e == 8'hFF && f == 23'd0 && !s) return {1'b0, 8'hFF, 23'd0};
      if (e == 8'hFF || s) return QNAN;
      ue = int'(e) - 127;
      scaled = 64'({1'b1, f}) << 23;
      if (ue % 2 != 0) begin
         scaled = scaled << 1;
         ue = ue - 1;
      end
      lo = 0;
      hi = 64'd1 << 25;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= scaled) lo = mid;
         else hi = mid;
      end
      return {1'b0, 8'(ue / 2 + 127), lo[22:0]};
   endfunction

   task automatic scramble_inputs();
      io.i_sign = 1'($urandom);
      io.i_exp  = 8'($urandom);
      io.i_frac = 23'($urandom);
   endtask

   // Called #1 after an edge; holds reset for n edges with the operand, checks cleared outputs, releases.
   task automatic load_op(input string name, input logic s, input logic [7:0] e,
                          input logic [22:0] f, input int n);
      reset     = 1'b1;
      io.i_sign = s;
      io.i_exp  = e;
      io.i_frac = f;
      repeat (n) @(posedge clk);
      #1;
      check({name, "_rst"}, 64'(dut_out()), 64'd0);
      reset = 1'b0;
   endtask

   task automatic run_to_result(input string name, input logic [31:0] res);
      int busy_bad = 0;
      for (int k = 1; k <= 25; k++) begin
         scramble_inputs();
         @(posedge clk);
         #1;
         if (dut_out() != 33'd0) busy_bad++;
      end
      check({name, "_busy"}, 64'(busy_bad), 64'd0);
      scramble_inputs();
      @(posedge clk);
      #1;
      check(name, 64'(dut_out()), 64'({1'b1, res}));
   endtask

   task automatic hold_stable(input string name, input int cycles, input logic [31:0] res);
      int moved = 0;
      for (int k = 0; k < cycles; k++) begin
         scramble_inputs();
         @(posedge clk);
         #1;
         if (dut_out() != {1'b1, res}) moved++;
      end
      check(name, 64'(moved), 64'd0);
   endtask

   vec_t vecs [14];

   initial begin
      logic        s;
      logic [7:0]  e;
      logic [22:0] f;
      int          pick;
      int          pre_bad;

      vecs[0]  = '{"sqrt_1p0",   1'b0, 8'd127, 23'h000000, {1'b0, 8'd127, 23'h000000}};
      vecs[1]  = '{"sqrt_2p0",   1'b0, 8'd128, 23'h000000, {1'b0, 8'd127, 23'h3504F3}};
      vecs[2]  = '{"sqrt_4p0",   1'b0, 8'd129, 23'h000000, {1'b0, 8'd128, 23'h000000}};
      vecs[3]  = '{"sqrt_0p25",  1'b0, 8'd125, 23'h000000, {1'b0, 8'd126, 23'h000000}};
      vecs[4]  = '{"pos_zero",   1'b0, 8'd0,   23'h000000, {1'b0, 8'd0,   23'h000000}};
      vecs[5]  = '{"neg_zero",   1'b1, 8'd0,   23'h000000, {1'b1, 8'd0,   23'h000000}};
      vecs[6]  = '{"pos_inf",    1'b0, 8'd255, 23'h000000, {1'b0, 8'd255, 23'h000000}};
      vecs[7]  = '{"neg_inf",    1'b1, 8'd255, 23'h000000, QNAN};
      vecs[8]  = '{"neg_4p0",    1'b1, 8'd129, 23'h000000, QNAN};
      vecs[9]  = '{"nan_in",     1'b0, 8'd255, 23'h000123, QNAN};
      vecs[10] = '{"denorm",     1'b0, 8'd0,   23'h123456, {1'b0, 8'd0,   23'h000000}};
      vecs[11] = '{"neg_denorm", 1'b1, 8'd0,   23'h000005, {1'b1, 8'd0,   23'h000000}};
      vecs[12] = '{"max_norm",   1'b0, 8'd254, 23'h7FFFFF, {1'b0, 8'd190, 23'h7FFFFF}};
      vecs[13] = '{"min_norm",   1'b0, 8'd1,   23'h000000, {1'b0, 8'd64,  23'h000000}};

      #1;
      load_op("tp_12p25", 1'b0, 8'h82, 23'h440000, 3);
      run_to_result("tp_12p25", {1'b0, 8'd128, 23'h600000});
      hold_stable("tp_12p25_hold", 100, {1'b0, 8'd128, 23'h600000});

      load_op("tp_25p0", 1'b0, 8'h83, 23'h480000, 2);
      run_to_result("tp_25p0", {1'b0, 8'd129, 23'h200000});
      hold_stable("tp_25p0_hold", 20, {1'b0, 8'd129, 23'h200000});

      for (int i = 0; i < 14; i++) begin
         load_op(vecs[i].name, vecs[i].s, vecs[i].e, vecs[i].f, 1);
         run_to_result(vecs[i].name, vecs[i].res);
      end

      // Abort: 12.25 runs for 9 edges, reset is sampled at edge 10 with 25.0 loaded instead.
      load_op("abort_first", 1'b0, 8'h82, 23'h440000, 2);
      pre_bad = 0;
      for (int k = 1; k <= 9; k++) begin
         scramble_inputs();
         @(posedge clk);
         #1;
         if (dut_out() != 33'd0) pre_bad++;
      end
      check("abort_pre", 64'(pre_bad), 64'd0);
      load_op("abort_new", 1'b0, 8'h83, 23'h480000, 1);
      run_to_result("abort_new", {1'b0, 8'd129, 23'h200000});

      for (int n = 0; n < 150; n++) begin
         s    = ($urandom_range(0, 7) == 0);
         pick = $urandom_range(0, 19);
         e    = (pick == 0) ? 8'd0 : (pick == 1) ? 8'd255 : 8'($urandom_range(1, 254));
         f    = (pick == 2) ? 23'd0 : 23'($urandom);
         load_op("rand", s, e, f, $urandom_range(1, 3));
         run_to_result("rand", sqrt_model(s, e, f));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
